mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port synchronous CPU RAM (1024 x 32 bit words) between the instruction-fetch path and the load/store path of the rv32i core. It grants at most one memory access per cycle using round-robin priority, drives the RAM port from the winning requester, and returns read data one cycle after the grant. Out-of-range or misaligned accesses are rejected with an error response and never reach the RAM.

## Interface
Parameters:
- ADDR_W, 10: RAM word-address width (2^ADDR_W words).
- DATA_W, 32: data width; fixed at 32, byte enables are DATA_W/8.

Ports:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- if_req  in  1  fetch request, level, held until granted.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch error; qualified by if_rvalid.
- d_req  in  1  data request, level, held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response valid (loads, stores and errors).
- d_rdata  out  32  load data.
- d_err  out  1  data error; qualified by d_rvalid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we = 0.

## Operation
- Requesters must hold req, addr, we, be and wdata stable until gnt. They may drop req only after the grant.
- Arbitration happens in the same cycle as the request. If only one requester asserts req, it is granted. If both assert req, the grant goes to the requester not granted most recently.
- The priority pointer updates only on a contended grant. Its reset value makes data win the first contention.
- Error checks:
  - Fetch: if_addr[1:0] != 0 or if_addr[31:ADDR_W+2] != 0 is an error.
  - Data: d_addr[31:ADDR_W+2] != 0 is an error. d_addr[1:0] is ignored; byte lanes are selected by d_be.
- An erroring request is still granted and consumes that cycle's slot. mem_en = 0 for it. Next cycle: rvalid = 1, err = 1, rdata = 0.
- Granted, non-erroring access:
  - mem_en = 1 and mem_addr = addr[ADDR_W+1:2].
  - Load: mem_we = 0.
  - Store: mem_we = d_be and mem_wdata = d_wdata.
- Fetch is always a read.
- A store with d_be = 0 is a legal no-op write and still acknowledges.
- No grant: mem_en = 0, mem_we = 0.

## Timing
- Grant is combinational from req and the pointer (zero latency). mem_* outputs are combinational from the selected requester.
- Response: grant in cycle N gives rvalid = 1 in cycle N+1 for exactly one cycle. rdata = mem_rdata for loads and fetches, 0 for stores and errors. err is registered.
- Throughput: one grant per cycle. A grant may coincide with the previous grant's response. Each requester sees responses in grant order (at most one in flight per port).
- Example: both requesters request every cycle. Grants alternate D, IF, D, IF starting from reset, and each port receives a response every other cycle.
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_en = 0. mem_we = 0. rdata = 0. Priority pointer = data-first.
- Reset mid-operation: any response pending for the cycle after reset is dropped. Nothing is replayed. A store already presented with mem_en in the cycle rst rises is undefined at the RAM.
- Simultaneous request and response on the same port is allowed.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W default;
  - requester-id enum REQ_IF / REQ_D;
  - error-check helper constants (alignment mask, upper-address mask).
- Sub-module rr_arb2: two-way round-robin arbiter (req[1:0], gnt one-hot, pointer register).
- The top level holds the error checks, port muxing and the response pipeline register: valid, id, err, is_store.

## Test plan
- Fetch only: if_addr = 0x8 with RAM[2] = 0x00500093. Expect if_gnt in the same cycle, mem_addr = 2, and next cycle if_rvalid = 1, if_rdata = 0x00500093, if_err = 0.
- Contention from reset: both requesters request continuously for 4 cycles. Expect grant order D, IF, D, IF, with responses in cycles 1 through 4 on the matching ports.
- Store then load: d_we = 1, d_be = 4'b0011, d_addr = 0x10, d_wdata = 0xAABBCCDD over old value 0x11223344, then a load from 0x10. Expect d_rdata = 0x1122CCDD.
- Errors:
  - if_addr = 0x6 gives if_err = 1, if_rdata = 0 and mem_en = 0.
  - d_addr = 0x1000 gives d_err = 1 and mem_en = 0.
- Reset mid-operation: grant a load, then assert rst in the next cycle. Expect d_rvalid = 0 and all outputs at their reset values. After release, the first contended grant goes to D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU RAM arbiter: requester ids, grant vector
// indices and the address-legality masks.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // Positions of each requester inside the two-bit request/grant vectors.
  localparam int IDX_IF = 0;
  localparam int IDX_D  = 1;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  // Byte-address bits above the RAM window; any of them set is out of range.
  function automatic logic [31:0] upper_mask(input int addr_w);
    logic [31:0] span;
    span = (32'h1 << (addr_w + 2)) - 32'h1;
    return ~span;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins the
// next contention and only moves when both sides request together.
module rr_arb2 #(
  parameter logic PTR_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;
  logic contended;

  assign contended = &req;

  always_comb begin
    gnt = req;
    if (contended) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // The winner was ptr, so the other side is favoured next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else if (contended) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port CPU RAM between instruction fetch and load/store.
// Grants and RAM port are combinational; responses return one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [31:0] UPPER_MASK = upper_mask(ADDR_W);

  logic [1:0] req_v;
  logic [1:0] gnt;
  logic       if_bad;
  logic       d_bad;
  logic       sel_d;
  logic       sel_err;
  logic       sel_store;

  // Requests are masked while reset is held so the RAM port stays idle.
  assign req_v[IDX_IF] = if_req & ~rst;
  assign req_v[IDX_D]  = d_req & ~rst;

  rr_arb2 #(
    .PTR_RST (1'b1)
  ) u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req_v),
    .gnt (gnt)
  );

  assign if_gnt = gnt[IDX_IF];
  assign d_gnt  = gnt[IDX_D];

  assign if_bad = (|(if_addr & ALIGN_MASK)) | (|(if_addr & UPPER_MASK));
  assign d_bad  = |(d_addr & UPPER_MASK);

  assign sel_d     = gnt[IDX_D];
  assign sel_err   = sel_d ? d_bad : if_bad;
  assign sel_store = sel_d & d_we;

  assign mem_en    = (|gnt) & ~sel_err;
  assign mem_we    = (sel_d & d_we & ~d_bad) ? d_be : '0;
  assign mem_addr  = sel_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
  assign mem_wdata = d_wdata;

  // ---- stage p1: response of the access granted last cycle ----
  logic    vld_p1;
  req_id_e id_p1;
  logic    err_p1;
  logic    store_p1;
  logic    rd_ok_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      id_p1    <= REQ_IF;
      err_p1   <= 1'b0;
      store_p1 <= 1'b0;
    end else begin
      vld_p1   <= |gnt;
      id_p1    <= sel_d ? REQ_D : REQ_IF;
      err_p1   <= (|gnt) & sel_err;
      store_p1 <= sel_store;
    end
  end

  assign rd_ok_p1 = vld_p1 & ~err_p1 & ~store_p1;

  assign if_rvalid = vld_p1 & (id_p1 == REQ_IF);
  assign d_rvalid  = vld_p1 & (id_p1 == REQ_D);
  assign if_err    = if_rvalid & err_p1;
  assign d_err     = d_rvalid & err_p1;
  assign if_rdata  = (if_rvalid & rd_ok_p1) ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid & rd_ok_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and a response
// scoreboard that pairs each grant with the response due one cycle later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  logic [31:0] ram [0:1023];

  mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[2] = 32'h0050_0093;
    ram[4] = 32'h1122_3344;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (if_q.size() > 0 && if_q[0].due == cyc) begin
      chk("if_rvalid", {31'b0, if_rvalid}, 32'h1);
      chk("if_err", {31'b0, if_err}, {31'b0, if_q[0].err});
      chk("if_rdata", if_rdata, if_q[0].data);
      void'(if_q.pop_front());
    end else if (if_rvalid !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL if_rvalid_unexpected: got %b expected 0 (cycle %0d)", if_rvalid, cyc);
    end
    if (d_q.size() > 0 && d_q[0].due == cyc) begin
      chk("d_rvalid", {31'b0, d_rvalid}, 32'h1);
      chk("d_err", {31'b0, d_err}, {31'b0, d_q[0].err});
      chk("d_rdata", d_rdata, d_q[0].data);
      void'(d_q.pop_front());
    end else if (d_rvalid !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL d_rvalid_unexpected: got %b expected 0 (cycle %0d)", d_rvalid, cyc);
    end
  end

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
  endtask

  task automatic exp_if(input logic err, input logic [31:0] data);
    if_q.push_back('{due: cyc + 1, err: err, data: data});
  endtask

  task automatic exp_d(input logic err, input logic [31:0] data);
    d_q.push_back('{due: cyc + 1, err: err, data: data});
  endtask

  // Check the combinational grant/RAM side mid-cycle, then advance one cycle.
  task automatic tick(input logic e_ig, input logic e_dg, input logic e_en,
                      input logic [9:0] e_addr, input logic [3:0] e_we,
                      input logic [31:0] e_wd);
    @(negedge clk);
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_ig});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, e_dg});
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
    chk("mem_we", {28'b0, mem_we}, {28'b0, e_we});
    if (e_en) chk("mem_addr", {22'b0, mem_addr}, {22'b0, e_addr});
    if (e_we != 4'b0000) chk("mem_wdata", mem_wdata, e_wd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst_if_err", {31'b0, if_err}, 32'h0);
    chk("rst_d_err", {31'b0, d_err}, 32'h0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Requests held during reset must not be granted.
    if_req = 1'b1; if_addr = 32'h8;
    d_req  = 1'b1; d_addr  = 32'h10;
    check_reset_vals();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch only.
    if_req = 1'b1; if_addr = 32'h8;
    exp_if(1'b0, 32'h0050_0093);
    tick(1, 0, 1, 10'd2, 4'h0, 32'h0);
    idle_inputs();
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);

    // Contention from reset pointer: D, IF, D, IF.
    if_req = 1'b1; if_addr = 32'h8;
    d_req  = 1'b1; d_addr  = 32'h10;
    exp_d(1'b0, 32'h1122_3344);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    exp_if(1'b0, 32'h0050_0093);
    tick(1, 0, 1, 10'd2, 4'h0, 32'h0);
    exp_d(1'b0, 32'h1122_3344);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    exp_if(1'b0, 32'h0050_0093);
    tick(1, 0, 1, 10'd2, 4'h0, 32'h0);
    idle_inputs();
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);

    // Partial store, then load back the merged word.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hAABB_CCDD;
    exp_d(1'b0, 32'h0);
    tick(0, 1, 1, 10'd4, 4'b0011, 32'hAABB_CCDD);
    d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
    exp_d(1'b0, 32'h1122_CCDD);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    // Store with no byte lanes still acknowledges and leaves the word alone.
    d_we = 1'b1; d_be = 4'b0000; d_wdata = 32'hFFFF_FFFF;
    exp_d(1'b0, 32'h0);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    // Low address bits are ignored for data accesses.
    d_we = 1'b0; d_addr = 32'h13;
    exp_d(1'b0, 32'h1122_CCDD);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    idle_inputs();
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);

    // Error responses never reach the RAM.
    if_req = 1'b1; if_addr = 32'h6;
    exp_if(1'b1, 32'h0);
    tick(1, 0, 0, 10'd0, 4'h0, 32'h0);
    if_addr = 32'h1000;
    exp_if(1'b1, 32'h0);
    tick(1, 0, 0, 10'd0, 4'h0, 32'h0);
    idle_inputs();
    d_req = 1'b1; d_addr = 32'h1000;
    exp_d(1'b1, 32'h0);
    tick(0, 1, 0, 10'd0, 4'h0, 32'h0);
    d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8000_0010; d_wdata = 32'h1234_5678;
    exp_d(1'b1, 32'h0);
    tick(0, 1, 0, 10'd0, 4'h0, 32'h0);
    idle_inputs();
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);

    // Contended load granted to D (pointer moves to IF), then reset.
    if_req = 1'b1; if_addr = 32'h8;
    d_req  = 1'b1; d_addr  = 32'h10;
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    idle_inputs();
    rst = 1'b1;
    check_reset_vals();
    rst = 1'b0;

    // First contention after reset goes to D again.
    if_req = 1'b1; if_addr = 32'h8;
    d_req  = 1'b1; d_addr  = 32'h10;
    exp_d(1'b0, 32'h1122_CCDD);
    tick(0, 1, 1, 10'd4, 4'h0, 32'h0);
    d_req = 1'b0;
    exp_if(1'b0, 32'h0050_0093);
    tick(1, 0, 1, 10'd2, 4'h0, 32'h0);
    idle_inputs();
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);
    tick(0, 0, 0, 10'd0, 4'h0, 32'h0);

    chk("if_q_drained", if_q.size(), 32'h0);
    chk("d_q_drained", d_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
